// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//   APB requester that turns single commands from the control side into a
//   two-phase APB transfer (SETUP, ACCESS). It returns exactly one response
//   per command: read data, a slave error, or a local timeout abort.
//   It accepts one command at a time and has no response back-pressure.
//
// Parameters
//   AWIDTH   APB address width
//   DWIDTH   APB data width
//   TIMEOUT  max ACCESS cycles with PREADY=0 before abort (0 = wait forever)
//
// Ports
//   PCLK, PRESET        clock, synchronous active-high reset
//   cmd_valid/ready     command handshake (accept when both high at posedge)
//   cmd_write/addr/wdata  command direction, address, write data
//   rsp_valid           one-cycle response strobe
//   rsp_rdata           read data (0 for writes and timeouts), held
//   rsp_err             PSLVERR seen or timeout, held
//   rsp_timeout         transfer aborted by timeout, held
//   PSEL..PWDATA        registered APB requester outputs
//   PRDATA/PREADY/PSLVERR  APB completer inputs
// -----------------------------------------------------------------------------
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no transfer; cmd_ready high; APB address/data keep last value
// S_SETUP | PSEL=1, PENABLE=0 for exactly one cycle
// S_ACCESS| PSEL=PENABLE=1 until PREADY or timeout
// -----------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // A zero TIMEOUT still gets a 1-bit counter so the logic stays legal.
  localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_LAST);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              psel_nxt, penable_nxt, pwrite_nxt;
  logic [AWIDTH-1:0] paddr_nxt;
  logic [DWIDTH-1:0] pwdata_nxt;
  logic              rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic [DWIDTH-1:0] rsp_rdata_nxt;
  logic              timeout_hit;

  assign cmd_ready = (state == S_IDLE) && !PRESET;

  // Abort on the edge that would complete the TIMEOUT-th wait cycle.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    psel_nxt        = PSEL;
    penable_nxt     = PENABLE;
    pwrite_nxt      = PWRITE;
    paddr_nxt       = PADDR;
    pwdata_nxt      = PWDATA;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          paddr_nxt  = cmd_addr;
          pwrite_nxt = cmd_write;
          pwdata_nxt = cmd_wdata;
          psel_nxt   = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
        state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = PSLVERR;
          rsp_timeout_nxt = 1'b0;
          rsp_rdata_nxt   = PWRITE ? '0 : PRDATA;
          state_nxt       = S_IDLE;
        end else if (timeout_hit) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_rdata_nxt   = '0;
          state_nxt       = S_IDLE;
        end else if (cnt != {CW{1'b1}}) begin
          // saturate rather than wrap when TIMEOUT is 0
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= S_IDLE;
      cnt         <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      PSEL        <= psel_nxt;
      PENABLE     <= penable_nxt;
      PWRITE      <= pwrite_nxt;
      PADDR       <= paddr_nxt;
      PWDATA      <= pwdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

endmodule
